// File: rtl/hazard_scoreboard_if.sv
// Decode-side bundle between the decode stage and the RAW hazard scoreboard.
interface hazard_scoreboard_if #(
  parameter int unsigned CNT_W = 16
);
  localparam int unsigned REG_W = 4;

  logic             id_valid;
  logic [REG_W-1:0] id_src1;
  logic [REG_W-1:0] id_src2;
  logic             id_two_src;
  logic             id_ignore_hazard;
  logic             id_wb_en;
  logic             id_mem_read;
  logic [REG_W-1:0] id_dest;
  logic             exe_branch_taken;
  logic             mem_stall;
  logic             hazard;
  logic             freeze;
  logic             flush;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output id_valid, id_src1, id_src2, id_two_src, id_ignore_hazard,
           id_wb_en, id_mem_read, id_dest, exe_branch_taken, mem_stall,
    input  hazard, freeze, flush, stall_count
  );

  modport slave (
    input  id_valid, id_src1, id_src2, id_two_src, id_ignore_hazard,
           id_wb_en, id_mem_read, id_dest, exe_branch_taken, mem_stall,
    output hazard, freeze, flush, stall_count
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Tracks destinations in flight in EXE/MEM/WB and raises the decode RAW stall,
// plus freeze/flush pass-through and a saturating stall-cycle counter.
module hazard_scoreboard #(
  parameter bit          FORWARDING_EN = 1'b0,
  parameter bit          WB_BYPASS     = 1'b1,
  parameter int unsigned CNT_W         = 16
) (
  input logic               clk,
  input logic               rst,
  hazard_scoreboard_if.slave bus
);
  localparam int unsigned REG_W = 4;

  typedef struct packed {
    logic             valid;
    logic             wb_en;
    logic             mem_read;
    logic [REG_W-1:0] dest;
  } slot_t;

  slot_t            s_exe;
  slot_t            s_mem;
  slot_t            s_wb;
  logic [CNT_W-1:0] count;

  logic hazard_c;
  logic flush_c;
  logic raw1;
  logic raw2;

  function automatic logic hit(input slot_t s, input logic [REG_W-1:0] r);
    return s.valid & s.wb_en & (s.dest == r);
  endfunction

  // With forwarding only a load still sitting in EXE cannot be bypassed in time.
  function automatic logic raw(input logic [REG_W-1:0] r);
    logic exe_m;
    logic mem_m;
    logic wb_m;
    exe_m = hit(s_exe, r) & (!FORWARDING_EN || s_exe.mem_read);
    mem_m = !FORWARDING_EN && hit(s_mem, r);
    wb_m  = !FORWARDING_EN && !WB_BYPASS && hit(s_wb, r);
    return exe_m | mem_m | wb_m;
  endfunction

  always_comb begin
    raw1     = raw(bus.id_src1);
    raw2     = bus.id_two_src & raw(bus.id_src2);
    hazard_c = bus.id_valid & ~bus.id_ignore_hazard & (raw1 | raw2);
    flush_c  = bus.exe_branch_taken & ~bus.mem_stall;
  end

  assign bus.hazard      = hazard_c;
  assign bus.freeze      = bus.mem_stall;
  assign bus.flush       = flush_c;
  assign bus.stall_count = count;

  // Slots advance only when memory is ready; stalls and flushes inject bubbles.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_exe <= '0;
      s_mem <= '0;
      s_wb  <= '0;
      count <= '0;
    end else if (!bus.mem_stall) begin
      s_wb           <= s_mem;
      s_mem          <= s_exe;
      s_exe.valid    <= bus.id_valid & ~hazard_c & ~flush_c;
      s_exe.wb_en    <= bus.id_wb_en;
      s_exe.mem_read <= bus.id_mem_read;
      s_exe.dest     <= bus.id_dest;
      if (hazard_c && (count != '1)) begin
        count <= count + CNT_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: three configurations driven in lockstep against a
// pipeline-history reference model, plus directed vectors for the corner cases.
module tb_hazard_scoreboard;
  typedef struct packed {
    logic       rst;
    logic       v;
    logic [3:0] s1;
    logic [3:0] s2;
    logic       two;
    logic       ign;
    logic       wb;
    logic       mr;
    logic [3:0] d;
    logic       br;
    logic       ms;
  } in_t;

  typedef struct packed {
    logic       v;
    logic       wb;
    logic       mr;
    logic [3:0] d;
  } ent_t;

  typedef struct {
    in_t x;
    bit  eh;
    bit  ef;
    int  ec;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  in_t  cur;
  always #5 clk = ~clk;

  hazard_scoreboard_if #(.CNT_W(4))  if0 ();
  hazard_scoreboard_if #(.CNT_W(6))  if1 ();
  hazard_scoreboard_if #(.CNT_W(16)) if2 ();

  assign rst = cur.rst;
  assign {if0.id_valid, if0.id_src1, if0.id_src2, if0.id_two_src, if0.id_ignore_hazard} = {cur.v, cur.s1, cur.s2, cur.two, cur.ign};
  assign {if0.id_wb_en, if0.id_mem_read, if0.id_dest, if0.exe_branch_taken, if0.mem_stall} = {cur.wb, cur.mr, cur.d, cur.br, cur.ms};
  assign {if1.id_valid, if1.id_src1, if1.id_src2, if1.id_two_src, if1.id_ignore_hazard} = {cur.v, cur.s1, cur.s2, cur.two, cur.ign};
  assign {if1.id_wb_en, if1.id_mem_read, if1.id_dest, if1.exe_branch_taken, if1.mem_stall} = {cur.wb, cur.mr, cur.d, cur.br, cur.ms};
  assign {if2.id_valid, if2.id_src1, if2.id_src2, if2.id_two_src, if2.id_ignore_hazard} = {cur.v, cur.s1, cur.s2, cur.two, cur.ign};
  assign {if2.id_wb_en, if2.id_mem_read, if2.id_dest, if2.exe_branch_taken, if2.mem_stall} = {cur.wb, cur.mr, cur.d, cur.br, cur.ms};

  hazard_scoreboard #(.FORWARDING_EN(1'b0), .WB_BYPASS(1'b1), .CNT_W(4))  d0 (.clk(clk), .rst(rst), .bus(if0));
  hazard_scoreboard #(.FORWARDING_EN(1'b1), .WB_BYPASS(1'b1), .CNT_W(6))  d1 (.clk(clk), .rst(rst), .bus(if1));
  hazard_scoreboard #(.FORWARDING_EN(1'b0), .WB_BYPASS(1'b0), .CNT_W(16)) d2 (.clk(clk), .rst(rst), .bus(if2));

  logic [31:0] hz [3];
  logic [31:0] fl [3];
  logic [31:0] fz [3];
  logic [31:0] cd [3];
  assign hz[0] = 32'(if0.hazard); assign fl[0] = 32'(if0.flush); assign fz[0] = 32'(if0.freeze); assign cd[0] = 32'(if0.stall_count);
  assign hz[1] = 32'(if1.hazard); assign fl[1] = 32'(if1.flush); assign fz[1] = 32'(if1.freeze); assign cd[1] = 32'(if1.stall_count);
  assign hz[2] = 32'(if2.hazard); assign fl[2] = 32'(if2.flush); assign fz[2] = 32'(if2.freeze); assign cd[2] = 32'(if2.stall_count);

  // Reference model: per config, the last three issued entries (index 0 = youngest).
  ent_t pipe [3][3];
  int   mcnt [3];
  bit   mh   [3];
  int   checks = 0;
  int   errors = 0;

  function automatic bit cfg_fwd(input int c); return c == 1; endfunction
  function automatic bit cfg_byp(input int c); return c != 2; endfunction
  function automatic int cfg_max(input int c);
    return (c == 0) ? 15 : (c == 1) ? 63 : 65535;
  endfunction

  function automatic in_t mk(input bit r, input bit v, input int s1, input int s2, input bit two,
                             input bit ign, input bit wb, input bit mr, input int d, input bit br, input bit ms);
    in_t x;
    x = '{rst: r, v: v, s1: 4'(s1), s2: 4'(s2), two: two, ign: ign, wb: wb, mr: mr, d: 4'(d), br: br, ms: ms};
    return x;
  endfunction

  function automatic bit model_hazard(input int c, input in_t x);
    bit r1 = 0;
    bit r2 = 0;
    for (int age = 0; age < 3; age++) begin
      ent_t e = pipe[c][age];
      if (!(e.v && e.wb)) continue;
      if (age == 2 && cfg_byp(c)) continue;
      if (cfg_fwd(c) && !(age == 0 && e.mr)) continue;
      if (e.d == x.s1) r1 = 1;
      if (x.two && e.d == x.s2) r2 = 1;
    end
    return x.v && !x.ign && (r1 || r2);
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic settle(input in_t x, input bit do_chk);
    cur = x;
    #1;
    for (int c = 0; c < 3; c++) begin
      mh[c] = model_hazard(c, x);
      if (do_chk) begin
        chk($sformatf("hazard d%0d", c), hz[c], 32'(mh[c]));
        chk($sformatf("flush d%0d", c), fl[c], 32'(x.br && !x.ms));
        chk($sformatf("freeze d%0d", c), fz[c], 32'(x.ms));
        chk($sformatf("stall_count d%0d", c), cd[c], 32'(mcnt[c]));
      end
    end
  endtask

  task automatic advance();
    @(posedge clk);
    for (int c = 0; c < 3; c++) begin
      if (cur.rst) begin
        for (int a = 0; a < 3; a++) pipe[c][a] = '0;
        mcnt[c] = 0;
      end else if (!cur.ms) begin
        pipe[c][2] = pipe[c][1];
        pipe[c][1] = pipe[c][0];
        pipe[c][0] = '{v: cur.v && !mh[c] && !cur.br, wb: cur.wb, mr: cur.mr, d: cur.d};
        if (mh[c] && mcnt[c] < cfg_max(c)) mcnt[c]++;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    settle(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
    advance();
  endtask

  task automatic cycle(input in_t x);
    settle(x, 1'b1);
    advance();
  endtask

  vec_t tbl [24];

  initial begin
    // Directed vectors for the non-forwarding, WB-bypass configuration (d0).
    tbl[0]  = '{mk(0, 1, 0, 0, 0, 0, 1, 0, 1, 0, 0), 0, 0, 0};
    tbl[1]  = '{mk(0, 1, 1, 0, 0, 0, 1, 0, 2, 0, 0), 1, 0, 0};
    tbl[2]  = '{mk(0, 1, 1, 0, 0, 0, 1, 0, 2, 0, 0), 1, 0, 1};
    tbl[3]  = '{mk(0, 1, 1, 0, 0, 0, 1, 0, 2, 0, 0), 0, 0, 2};
    tbl[4]  = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0, 0, 2};
    tbl[5]  = '{mk(0, 1, 0, 0, 0, 0, 1, 0, 3, 0, 0), 0, 0, 2};
    tbl[6]  = '{mk(0, 1, 4, 3, 1, 0, 0, 0, 0, 0, 0), 1, 0, 2};
    tbl[7]  = '{mk(0, 1, 4, 3, 0, 0, 0, 0, 0, 0, 0), 0, 0, 3};
    tbl[8]  = '{mk(0, 1, 0, 0, 0, 0, 1, 0, 5, 0, 0), 0, 0, 3};
    tbl[9]  = '{mk(0, 1, 5, 5, 1, 1, 0, 0, 0, 0, 0), 0, 0, 3};
    tbl[10] = '{mk(0, 1, 0, 0, 0, 0, 1, 0, 6, 0, 0), 0, 0, 3};
    tbl[11] = '{mk(0, 1, 6, 0, 0, 0, 1, 0, 11, 1, 0), 1, 1, 3};
    tbl[12] = '{mk(0, 1, 6, 0, 0, 0, 1, 0, 11, 0, 0), 1, 0, 4};
    tbl[13] = '{mk(0, 1, 6, 0, 0, 0, 1, 0, 11, 0, 0), 0, 0, 5};
    tbl[14] = '{mk(0, 1, 0, 0, 0, 0, 1, 0, 7, 0, 0), 0, 0, 5};
    for (int i = 15; i < 19; i++) tbl[i] = '{mk(0, 1, 7, 0, 0, 0, 1, 0, 13, 0, 1), 1, 0, 5};
    tbl[19] = '{mk(0, 1, 7, 0, 0, 0, 1, 0, 13, 0, 0), 1, 0, 5};
    tbl[20] = '{mk(0, 1, 7, 0, 0, 0, 1, 0, 13, 0, 0), 1, 0, 6};
    tbl[21] = '{mk(0, 1, 7, 0, 0, 0, 1, 0, 13, 0, 0), 0, 0, 7};
    tbl[22] = '{mk(0, 1, 0, 0, 0, 0, 1, 0, 12, 1, 0), 0, 1, 7};
    tbl[23] = '{mk(0, 1, 12, 0, 0, 0, 0, 0, 0, 0, 0), 0, 0, 7};

    for (int c = 0; c < 3; c++) begin
      for (int a = 0; a < 3; a++) pipe[c][a] = '0;
      mcnt[c] = 0;
    end

    do_reset();
    for (int i = 0; i < 24; i++) begin
      settle(tbl[i].x, 1'b1);
      chk($sformatf("vec%0d hazard", i), hz[0], 32'(tbl[i].eh));
      chk($sformatf("vec%0d flush", i), fl[0], 32'(tbl[i].ef));
      chk($sformatf("vec%0d count", i), cd[0], 32'(tbl[i].ec));
      advance();
    end

    // Forwarding: load-use stalls exactly one cycle; a non-load producer never stalls.
    do_reset();
    cycle(mk(0, 1, 0, 0, 0, 0, 1, 1, 2, 0, 0));
    settle(mk(0, 1, 0, 2, 1, 0, 1, 0, 9, 0, 0), 1'b1);
    chk("fwd load-use c1", hz[1], 32'd1);
    advance();
    settle(mk(0, 1, 0, 2, 1, 0, 1, 0, 9, 0, 0), 1'b1);
    chk("fwd load-use c2", hz[1], 32'd0);
    advance();
    cycle(mk(0, 1, 0, 0, 0, 0, 1, 0, 2, 0, 0));
    settle(mk(0, 1, 0, 2, 1, 0, 1, 0, 9, 0, 0), 1'b1);
    chk("fwd non-load", hz[1], 32'd0);
    advance();

    // No WB bypass: a dependent instruction waits three cycles.
    do_reset();
    cycle(mk(0, 1, 0, 0, 0, 0, 1, 0, 1, 0, 0));
    for (int i = 0; i < 4; i++) begin
      settle(mk(0, 1, 1, 0, 0, 0, 1, 0, 2, 0, 0), 1'b1);
      chk($sformatf("nobyp stall c%0d", i), hz[2], 32'(i < 3));
      advance();
    end

    // Reset with all three slots occupied discards them.
    do_reset();
    cycle(mk(0, 1, 0, 0, 0, 0, 1, 0, 8, 0, 0));
    cycle(mk(0, 1, 0, 0, 0, 0, 1, 1, 9, 0, 0));
    cycle(mk(0, 1, 0, 0, 0, 0, 1, 1, 10, 0, 0));
    settle(mk(1, 1, 10, 9, 1, 0, 1, 0, 3, 0, 0), 1'b1);
    advance();
    settle(mk(0, 1, 10, 9, 1, 0, 1, 0, 3, 0, 0), 1'b1);
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("post-rst hazard d%0d", c), hz[c], 32'd0);
      chk($sformatf("post-rst count d%0d", c), cd[c], 32'd0);
    end
    advance();

    // Self-dependent load repeated: drives the small counters into saturation.
    do_reset();
    for (int i = 0; i < 200; i++) cycle(mk(0, 1, 1, 0, 0, 0, 1, 1, 1, 0, 0));
    settle(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b1);
    chk("saturate d0", cd[0], 32'd15);
    chk("saturate d1", cd[1], 32'd63);
    advance();

    // Random traffic over a narrow register range to provoke frequent conflicts.
    for (int i = 0; i < 3000; i++) begin
      in_t x;
      x = mk($urandom_range(0, 63) == 0, $urandom_range(0, 7) != 0,
             $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1),
             $urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
             $urandom_range(0, 3), $urandom_range(0, 7) == 0, $urandom_range(0, 4) == 0);
      if ($urandom_range(0, 3) == 0) begin
        x.s1 = 4'($urandom_range(0, 15));
        x.d  = 4'($urandom_range(0, 15));
      end
      cycle(x);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Tracks destination registers of instructions in flight in EXE, MEM and WB, and raises the decode-stage `hazard` stall for read-after-write conflicts. Sits beside the decode stage. Consumes decoded source/destination fields and control bits. Drives the decode hazard input, the pipeline freeze/flush controls and a stall performance counter. Supports a forwarding mode in which only load-use conflicts stall.

## Interface
- `FORWARDING_EN`, 0: 1 = only load-use hazards stall; 0 = any RAW hazard against EXE/MEM stalls.
- `WB_BYPASS`, 1: 1 = register file writes before it is read in the same cycle, so the WB slot never causes a hazard.
- `CNT_W`, 16: stall counter width.
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `id_valid`  in  1  decode holds a real instruction.
- `id_src1`  in  4  first source register, Instruction[19:16].
- `id_src2`  in  4  second source register, already muxed: Rd for stores, Rm otherwise.
- `id_two_src`  in  1  `id_src2` is read.
- `id_ignore_hazard`  in  1  instruction reads no registers (e.g. branch).
- `id_wb_en`, `id_mem_read`  in  1 each  post-cond-check control bits of the decode instruction.
- `id_dest`  in  4  destination, Instruction[15:12].
- `exe_branch_taken`  in  1  branch resolved taken in EXE.
- `mem_stall`  in  1  memory not ready; whole pipeline holds.
- `hazard`  out  1  to decode; zeroes control signals and holds IF/ID.
- `freeze`  out  1  = `mem_stall`; holds all pipeline registers.
- `flush`  out  1  = `exe_branch_taken & ~mem_stall`; squashes IF/ID.
- `stall_count`  out  CNT_W  saturating count of cycles with `hazard`=1.

## Operation
- Three slots: S_EXE, S_MEM, S_WB. Each slot holds {valid, wb_en, mem_read, dest}.
- A slot matches a source `r` when: valid & wb_en & dest==r.
- `raw1` = S_EXE or S_MEM matches `id_src1`, or S_WB matches it with WB_BYPASS=0. `raw2` is the same for `id_src2`, gated by `id_two_src`.
- FORWARDING_EN=0: `hazard` = id_valid & ~id_ignore_hazard & (raw1|raw2).
- FORWARDING_EN=1: `hazard` is the same, but only an S_EXE match whose slot has mem_read=1 counts.
- `hazard` is combinational from the slots and the current id_* inputs. No registered delay.
- Advance on each clock when `mem_stall`=0:
  - S_WB←S_MEM, S_MEM←S_EXE.
  - S_EXE←{id_valid & ~hazard & ~flush, id_wb_en, id_mem_read, id_dest}. A stall or flush inserts a bubble.
- `mem_stall`=1: all slots hold; `stall_count` holds. `hazard` is still evaluated but has no effect.
- Simultaneous `exe_branch_taken` and `hazard`: `flush` wins. S_EXE gets a bubble and decode is squashed. `hazard` stays asserted combinationally and is harmless.
- `stall_count` increments when hazard & ~mem_stall, and saturates at all-ones.
- The `flush` and `freeze` outputs are pure combinational pass-through. No state of their own.

## Timing
- Reset (`rst` high at a rising edge): all slot valid bits = 0, `stall_count` = 0. `hazard` = 0 in the following cycle regardless of id_* inputs.
- Reset mid-operation discards all in-flight entries. No partial state survives.
- Hazard latency is 0 cycles: a conflicting instruction is held from the cycle it enters decode.
- Non-forwarding RAW against an instruction just issued stalls 2 cycles (slots EXE, MEM) with WB_BYPASS=1, and 3 cycles with WB_BYPASS=0.
- Forwarding load-use stalls exactly 1 cycle.
- Register 0..15 are all tracked. No register is hardwired.

## Test plan
- Reset, then decode ADD R1 (dest 1, wb_en). Next cycle decode SUB src1=1, FORWARDING_EN=0, WB_BYPASS=1 -> `hazard`=1 for 2 cycles, 0 on the third. `stall_count`=2.
- FORWARDING_EN=1: LDR R2 followed by ADD src2=2, two_src=1 -> `hazard`=1 for exactly 1 cycle. ADD with R2 after a non-load -> `hazard`=0.
- Store reading Rd=3 via `id_src2` with two_src=1 after MOV R3 -> hazard. Same with two_src=0 -> none. Branch with ignore_hazard=1 -> none.
- Stall with `mem_stall`=1 for 4 cycles while a hazard is pending -> slots, `hazard` and `stall_count` frozen. Release -> the hazard resolves on the same cycle count as without the stall.
- `exe_branch_taken`=1 during a hazard -> `flush`=1 and S_EXE gets a bubble. The next decode with src=prior dest sees only the older MEM/WB entries.
- Assert `rst` with 3 valid slots -> next cycle `hazard`=0 for a matching source and `stall_count`=0. Force 2^CNT_W+5 stall cycles -> counter holds at all-ones.
